// File: rtl/updown_sweep_ctrl_if.sv
// Control bus between the sweep controller and an N-bit up_down_counter.
// The controller drives enable, load, direction and preload value; the
// counter returns its active-low ripple-carry output.
interface updown_sweep_ctrl_if #(
    parameter int N = 4
);
    logic         cnt_en_b;
    logic         cnt_load_b;
    logic         cnt_up;
    logic [N-1:0] cnt_load_in;
    logic         cnt_rco_b;

    modport master (
        output cnt_en_b,
        output cnt_load_b,
        output cnt_up,
        output cnt_load_in,
        input  cnt_rco_b
    );

    modport slave (
        input  cnt_en_b,
        input  cnt_load_b,
        input  cnt_up,
        input  cnt_load_in,
        output cnt_rco_b
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: command sequencer for an N-bit up_down_counter.
// Loads a start value, counts in the requested direction and stops the
// counter after a programmed number of terminal-count wraps.
// Optional build macro SWEEP_AUTORELOAD_EN: reload the start value after
// every non-final wrap instead of letting the counter free-run.
module updown_sweep_ctrl #(
    parameter int N       = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir_up,
    input  logic [N-1:0]       init_val,
    input  logic [SWEEP_W-1:0] sweeps,
    input  logic               abort,
    updown_sweep_ctrl_if.master ctr,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_cnt_en_b;
    logic               r_cnt_load_b;
    logic               r_cnt_up;
    logic [N-1:0]       r_cnt_load_in;
    logic [SWEEP_W-1:0] r_sweeps;
    logic [SWEEP_W-1:0] r_sweep_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;

    state_t             w_state_nxt;
    logic               w_cnt_en_b_nxt;
    logic               w_cnt_load_b_nxt;
    logic               w_cnt_up_nxt;
    logic [N-1:0]       w_cnt_load_in_nxt;
    logic [SWEEP_W-1:0] w_sweeps_nxt;
    logic [SWEEP_W-1:0] w_sweep_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_aborted_nxt;

    logic               w_wrap;
    logic               w_final;
    logic [SWEEP_W-1:0] w_sweep_inc;

    // A wrap only counts while the counter is actually enabled in RUN.
    assign w_wrap      = (r_state == S_RUN) && !r_cnt_en_b && !ctr.cnt_rco_b;
    assign w_sweep_inc = r_sweep_cnt + 1'b1;
    assign w_final     = (w_sweep_inc == r_sweeps);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        w_state_nxt       = r_state;
        w_cnt_en_b_nxt    = 1'b1;
        w_cnt_load_b_nxt  = 1'b1;
        w_cnt_up_nxt      = r_cnt_up;
        w_cnt_load_in_nxt = r_cnt_load_in;
        w_sweeps_nxt      = r_sweeps;
        w_sweep_cnt_nxt   = r_sweep_cnt;
        w_busy_nxt        = 1'b0;
        w_done_nxt        = 1'b0;
        w_aborted_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sweep_cnt_nxt = '0;
                    if (sweeps != '0) begin
                        w_cnt_up_nxt      = dir_up;
                        w_cnt_load_in_nxt = init_val;
                        w_sweeps_nxt      = sweeps;
                        w_cnt_load_b_nxt  = 1'b0;
                        w_busy_nxt        = 1'b1;
                        w_state_nxt       = S_LOAD;
                    end else begin
                        // Nothing to sweep: report completion without touching the counter.
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_LOAD: begin
                if (abort) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_en_b_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_RUN;
                end
            end

            S_RUN: begin
                if (abort) begin
                    // Abort wins over a coincident wrap: the wrap is not counted.
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (w_wrap) begin
                    w_sweep_cnt_nxt = w_sweep_inc;
                    if (w_final) begin
                        // Counter takes its final wrap on this edge, then holds.
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_en_b_nxt = 1'b0;
                        w_busy_nxt     = 1'b1;
`ifdef SWEEP_AUTORELOAD_EN
                        // Load overrides count, so the next sweep restarts at init_val.
                        w_cnt_load_b_nxt = 1'b0;
`else
                        w_cnt_load_b_nxt = 1'b1;
`endif
                    end
                end else begin
                    w_cnt_en_b_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt_en_b    <= 1'b1;
            r_cnt_load_b  <= 1'b1;
            r_cnt_up      <= 1'b1;
            r_cnt_load_in <= '0;
            r_sweeps      <= '0;
            r_sweep_cnt   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt_en_b    <= w_cnt_en_b_nxt;
            r_cnt_load_b  <= w_cnt_load_b_nxt;
            r_cnt_up      <= w_cnt_up_nxt;
            r_cnt_load_in <= w_cnt_load_in_nxt;
            r_sweeps      <= w_sweeps_nxt;
            r_sweep_cnt   <= w_sweep_cnt_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_aborted     <= w_aborted_nxt;
        end
    end

    assign ctr.cnt_en_b    = r_cnt_en_b;
    assign ctr.cnt_load_b  = r_cnt_load_b;
    assign ctr.cnt_up      = r_cnt_up;
    assign ctr.cnt_load_in = r_cnt_load_in;
    assign busy            = r_busy;
    assign done            = r_done;
    assign aborted         = r_aborted;
    assign sweep_cnt       = r_sweep_cnt;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with a behavioural 4-bit up/down counter
// closing the rco_b feedback loop.
module tb_updown_sweep_ctrl;

    localparam int N       = 4;
    localparam int SWEEP_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               dir_up;
    logic [N-1:0]       init_val;
    logic [SWEEP_W-1:0] sweeps;
    logic               abort;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [SWEEP_W-1:0] sweep_cnt;

    int checks = 0;
    int errors = 0;

    updown_sweep_ctrl_if #(.N(N)) bus ();

    updown_sweep_ctrl #(.N(N), .SWEEP_W(SWEEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir_up    (dir_up),
        .init_val  (init_val),
        .sweeps    (sweeps),
        .abort     (abort),
        .ctr       (bus),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .sweep_cnt (sweep_cnt)
    );

    always #5 clk = ~clk;

    // Counter model: load overrides count; rco_b low at the terminal value.
    logic [N-1:0] m_q = '0;
    always @(posedge clk) begin
        if (!bus.cnt_load_b)
            m_q <= bus.cnt_load_in;
        else if (!bus.cnt_en_b)
            m_q <= bus.cnt_up ? m_q + 1'b1 : m_q - 1'b1;
    end
    assign bus.cnt_rco_b = !(bus.cnt_up ? (m_q == 4'hF) : (m_q == 4'h0));

    // Observations gathered by watch().
    int wraps [8];
    int n_wraps;
    int en_cnt;
    int done_seen;
    int ab_seen;
    int load_low;
    bit timed_out;

`ifdef SWEEP_AUTORELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    // Called at a negedge: present a start request for one edge.
    task automatic do_start(input bit d, input logic [N-1:0] v, input logic [SWEEP_W-1:0] s);
        dir_up   = d;
        init_val = v;
        sweeps   = s;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step through a run, recording at which enabled cycle each wrap landed,
    // until done or aborted is seen. Optionally aborts just before wrap
    // number abort_wrap and fires a stray start mid-run.
    task automatic watch(input int abort_wrap, input bit glitch);
        logic [SWEEP_W-1:0] prev;
        n_wraps   = 0;
        en_cnt    = 0;
        done_seen = 0;
        ab_seen   = 0;
        load_low  = 0;
        timed_out = 1'b1;
        prev      = sweep_cnt;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (sweep_cnt != prev) begin
                if (n_wraps < 8) wraps[n_wraps] = en_cnt;
                n_wraps++;
                prev = sweep_cnt;
            end
            if (done)    done_seen++;
            if (aborted) ab_seen++;
            if (done || aborted) begin
                timed_out = 1'b0;
                break;
            end
            if (!bus.cnt_load_b) load_low++;
            if (!bus.cnt_en_b)   en_cnt++;
            if (glitch && en_cnt == 3 && !bus.cnt_en_b) begin
                start    = 1'b1;
                dir_up   = 1'b0;
                init_val = 4'd7;
                sweeps   = 8'd1;
            end
            if (abort_wrap != 0 && int'(sweep_cnt) == abort_wrap - 1 &&
                bus.cnt_up && m_q == 4'hF && !bus.cnt_en_b)
                abort = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        dir_up = 1'b0; init_val = '0; sweeps = '0;
        @(negedge clk); @(negedge clk);
        checks++; if (bus.cnt_en_b !== 1'b1)  begin errors++; $display("FAIL reset_en_b: got %b want 1", bus.cnt_en_b); end
        checks++; if (bus.cnt_load_b !== 1'b1) begin errors++; $display("FAIL reset_load_b: got %b want 1", bus.cnt_load_b); end
        checks++; if (bus.cnt_up !== 1'b1)    begin errors++; $display("FAIL reset_up: got %b want 1", bus.cnt_up); end
        checks++; if (bus.cnt_load_in !== 4'd0) begin errors++; $display("FAIL reset_load_in: got %0d want 0", bus.cnt_load_in); end
        checks++; if ({busy, done, aborted} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, aborted}); end
        checks++; if (sweep_cnt !== 8'd0)     begin errors++; $display("FAIL reset_sweep_cnt: got %0d want 0", sweep_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_abort_ignored();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, aborted, done} !== 3'b000) begin errors++; $display("FAIL idle_abort: got %b want 000", {busy, aborted, done}); end
    endtask

    task automatic test_up_two_sweeps();
        do_start(1'b1, 4'd0, 8'd2);
        checks++; if ({bus.cnt_load_b, bus.cnt_en_b, busy} !== 3'b011) begin errors++; $display("FAIL up2_load_phase: got %b want 011", {bus.cnt_load_b, bus.cnt_en_b, busy}); end
        checks++; if ({bus.cnt_up, bus.cnt_load_in} !== 5'b1_0000) begin errors++; $display("FAIL up2_load_val: got %b want 10000", {bus.cnt_up, bus.cnt_load_in}); end
        watch(0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL up2_timeout: got timeout want done"); end
        checks++; if (wraps[0] !== 16) begin errors++; $display("FAIL up2_wrap1: got %0d want 16", wraps[0]); end
        checks++; if (wraps[1] !== (RELOAD ? 33 : 32)) begin errors++; $display("FAIL up2_wrap2: got %0d want %0d", wraps[1], RELOAD ? 33 : 32); end
        checks++; if (done_seen !== 1 || sweep_cnt !== 8'd2) begin errors++; $display("FAIL up2_done: got done=%0d cnt=%0d want 1/2", done_seen, sweep_cnt); end
        checks++; if (load_low !== (RELOAD ? 1 : 0)) begin errors++; $display("FAIL up2_reloads: got %0d want %0d", load_low, RELOAD ? 1 : 0); end
        @(negedge clk);
        checks++; if ({done, busy, bus.cnt_en_b} !== 3'b001) begin errors++; $display("FAIL up2_after: got %b want 001", {done, busy, bus.cnt_en_b}); end
        checks++; if (m_q !== 4'd0) begin errors++; $display("FAIL up2_final_q: got %0d want 0", m_q); end
    endtask

    task automatic test_down_one_sweep();
        do_start(1'b0, 4'd15, 8'd1);
        checks++; if ({bus.cnt_up, bus.cnt_load_in} !== 5'b0_1111) begin errors++; $display("FAIL down1_load_val: got %b want 01111", {bus.cnt_up, bus.cnt_load_in}); end
        watch(0, 1'b0);
        checks++; if (timed_out || wraps[0] !== 16) begin errors++; $display("FAIL down1_wrap: got %0d (timeout=%0b) want 16", wraps[0], timed_out); end
        checks++; if (done_seen !== 1 || sweep_cnt !== 8'd1) begin errors++; $display("FAIL down1_done: got done=%0d cnt=%0d want 1/1", done_seen, sweep_cnt); end
        @(negedge clk);
        checks++; if (m_q !== 4'd15 || bus.cnt_en_b !== 1'b1) begin errors++; $display("FAIL down1_hold: got q=%0d en_b=%b want 15/1", m_q, bus.cnt_en_b); end
    endtask

    task automatic test_up_three_sweeps();
        do_start(1'b1, 4'd10, 8'd3);
        watch(0, 1'b0);
        checks++; if (timed_out || n_wraps !== 3) begin errors++; $display("FAIL up3_nwraps: got %0d want 3", n_wraps); end
        checks++; if (wraps[0] !== 6) begin errors++; $display("FAIL up3_wrap1: got %0d want 6", wraps[0]); end
        checks++; if (wraps[1] !== (RELOAD ? 13 : 22)) begin errors++; $display("FAIL up3_wrap2: got %0d want %0d", wraps[1], RELOAD ? 13 : 22); end
        checks++; if (wraps[2] !== (RELOAD ? 20 : 38)) begin errors++; $display("FAIL up3_wrap3: got %0d want %0d", wraps[2], RELOAD ? 20 : 38); end
        checks++; if (sweep_cnt !== 8'd3 || done_seen !== 1) begin errors++; $display("FAIL up3_done: got cnt=%0d done=%0d want 3/1", sweep_cnt, done_seen); end
        @(negedge clk);
        checks++; if (m_q !== 4'd0 || {bus.cnt_up, bus.cnt_load_in} !== 5'b1_1010) begin errors++; $display("FAIL up3_hold: got q=%0d up/in=%b want 0/11010", m_q, {bus.cnt_up, bus.cnt_load_in}); end
    endtask

    task automatic test_zero_sweeps();
        do_start(1'b1, 4'd4, 8'd0);
        checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_done: got %b want 10", {done, busy}); end
        checks++; if ({bus.cnt_load_b, bus.cnt_en_b} !== 2'b11) begin errors++; $display("FAIL zero_ctrl: got %b want 11", {bus.cnt_load_b, bus.cnt_en_b}); end
        checks++; if (sweep_cnt !== 8'd0) begin errors++; $display("FAIL zero_sweep_cnt: got %0d want 0", sweep_cnt); end
        @(negedge clk);
        checks++; if ({done, bus.cnt_load_b, bus.cnt_en_b} !== 3'b011) begin errors++; $display("FAIL zero_after: got %b want 011", {done, bus.cnt_load_b, bus.cnt_en_b}); end
    endtask

    task automatic test_abort_on_wrap();
        do_start(1'b1, 4'd0, 8'd5);
        watch(2, 1'b1);
        checks++; if (timed_out || ab_seen !== 1 || done_seen !== 0) begin errors++; $display("FAIL abort_pulse: got ab=%0d done=%0d want 1/0", ab_seen, done_seen); end
        checks++; if (sweep_cnt !== 8'd1 || wraps[0] !== 16) begin errors++; $display("FAIL abort_cnt: got cnt=%0d wrap1=%0d want 1/16", sweep_cnt, wraps[0]); end
        checks++; if ({bus.cnt_en_b, bus.cnt_load_b, busy} !== 3'b110) begin errors++; $display("FAIL abort_ctrl: got %b want 110", {bus.cnt_en_b, bus.cnt_load_b, busy}); end
        checks++; if ({bus.cnt_up, bus.cnt_load_in} !== 5'b1_0000) begin errors++; $display("FAIL abort_params: got %b want 10000", {bus.cnt_up, bus.cnt_load_in}); end
        @(negedge clk);
        checks++; if ({aborted, done} !== 2'b00) begin errors++; $display("FAIL abort_after: got %b want 00", {aborted, done}); end
    endtask

    task automatic test_reset_mid_run();
        do_start(1'b1, 4'd5, 8'd4);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({bus.cnt_en_b, bus.cnt_load_b, bus.cnt_up} !== 3'b111 || bus.cnt_load_in !== 4'd0) begin errors++; $display("FAIL rst_mid_ctrl: got %b/%0d want 111/0", {bus.cnt_en_b, bus.cnt_load_b, bus.cnt_up}, bus.cnt_load_in); end
        checks++; if ({busy, done, aborted} !== 3'b000 || sweep_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_flags: got %b/%0d want 000/0", {busy, done, aborted}, sweep_cnt); end
        do_start(1'b0, 4'd3, 8'd1);
        watch(0, 1'b0);
        checks++; if (timed_out || wraps[0] !== 4 || done_seen !== 1) begin errors++; $display("FAIL rst_mid_rerun: got wrap=%0d done=%0d want 4/1", wraps[0], done_seen); end
        @(negedge clk);
        checks++; if (m_q !== 4'd15 || sweep_cnt !== 8'd1) begin errors++; $display("FAIL rst_mid_final: got q=%0d cnt=%0d want 15/1", m_q, sweep_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle_abort_ignored();
        test_up_two_sweeps();
        test_down_one_sweep();
        test_up_three_sweeps();
        test_zero_sweeps();
        test_abort_on_wrap();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
